// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: iteration counter geometry and sequencer states.
package cordic_pkg;

  localparam int unsigned CORDIC_CNT_W    = 6;
  localparam int unsigned CORDIC_MAX_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iter_state_t;

endpackage

// File: rtl/cordic_iter_seq.sv
// CORDIC iteration sequencer: steps the ATAN ROM address / shift amount through a
// programmable number of iterations with stall, abort, restart and completion pulse.
module cordic_iter_seq
  import cordic_pkg::*;
#(
  parameter int unsigned CNT_W    = CORDIC_CNT_W,
  parameter int unsigned MAX_ITER = CORDIC_MAX_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             enable,
  input  logic [CNT_W:0]   niter,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam logic [CNT_W:0] MaxIterW = (CNT_W + 1)'(MAX_ITER);
  localparam logic [CNT_W:0] OneW     = (CNT_W + 1)'(1);

  iter_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   n_lat_q, n_lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Compare at CNT_W+1 bits so n_lat == 2**CNT_W is representable.
  assign last  = busy_q && ({1'b0, count_q} == (n_lat_q - OneW));
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_lat_d = n_lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      busy_d  = 1'b0;
    end else if (start) begin
      count_d = '0;
      if (niter != '0) begin
        state_d = RUN;
        busy_d  = 1'b1;
        n_lat_d = (niter > MaxIterW) ? MaxIterW : niter;
      end else begin
        // Zero-length run completes immediately without ever going busy.
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (last) begin
              state_d = DONE;
              count_d = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      n_lat_q <= MaxIterW;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_lat_q <= n_lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Self-checking bench for cordic_iter_seq: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural run model.
module tb_cordic_iter_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       enable;
  logic [6:0] niter;
  logic [5:0] count;
  logic       busy;
  logic       last;
  logic       done;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: a run is "busy with n iterations, currently at index idx".
  bit m_busy;
  bit m_done;
  int m_idx;
  int m_n;

  cordic_iter_seq dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .enable (enable),
    .niter  (niter),
    .count  (count),
    .busy   (busy),
    .last   (last),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
    m_n    = 32;
  endtask

  // Next-state of the model given current inputs, evaluated just before an edge.
  task automatic model_step();
    int n;
    n = int'(niter);
    if (abort) begin
      m_busy = 1'b0; m_idx = 0; m_done = 1'b0;
    end else if (start) begin
      m_idx = 0;
      if (n != 0) begin
        m_busy = 1'b1; m_done = 1'b0; m_n = (n > 32) ? 32 : n;
      end else begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (m_busy && enable) begin
      if (m_idx == m_n - 1) begin
        m_busy = 1'b0; m_idx = 0; m_done = 1'b1;
      end else begin
        m_idx++; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [5:0] exp_count;
    logic       exp_last;
    exp_count = 6'(m_idx);
    exp_last  = m_busy && (m_idx == m_n - 1);
    vectors++;
    assert (count === exp_count) else begin
      miscompares++;
      $error("FAIL %s count got %0d exp %0d", tag, count, exp_count);
    end
    assert (busy === logic'(m_busy)) else begin
      miscompares++;
      $error("FAIL %s busy got %b exp %b", tag, busy, m_busy);
    end
    assert (done === logic'(m_done)) else begin
      miscompares++;
      $error("FAIL %s done got %b exp %b", tag, done, m_done);
    end
    assert (last === exp_last) else begin
      miscompares++;
      $error("FAIL %s last got %b exp %b", tag, last, exp_last);
    end
  endtask

  task automatic cycle(input bit s, input bit a, input bit e, input int n, input string tag);
    start  = s;
    abort  = a;
    enable = e;
    niter  = 7'(n);
    model_step();
    @(posedge clock);
    #1;
    check(tag);
  endtask

  initial begin
    bit [6:0] stall_pat;
    int       done_seen;
    reset = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b0; niter = '0;
    model_reset();
    #12;
    check("reset_state");
    reset = 1'b1;

    // Async reset mid-run at count=5.
    cycle(1, 0, 1, 16, "rst_start");
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, "rst_run");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge clock);
    #1;
    check("reset_held");
    reset = 1'b1;

    // Nominal 16-iteration run: done must land exactly 16 edges after start.
    cycle(1, 0, 1, 16, "nom_start");
    done_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 0, 1, 0, "nominal");
      if (done === 1'b1) done_seen = i;
    end
    vectors++;
    assert (done_seen == 16) else begin
      miscompares++;
      $error("FAIL nom_done_edge got %0d exp 16", done_seen);
    end

    // Stall pattern 1,0,0,1,1,0,1 on a 4-iteration run.
    stall_pat = 7'b1011001;
    cycle(1, 0, 1, 4, "stall_start");
    for (int i = 0; i < 7; i++) cycle(0, 0, stall_pat[i], 0, "stall");
    cycle(0, 0, 1, 0, "stall_after");

    // Clamp to 32, then zero-length run.
    cycle(1, 0, 1, 40, "clamp_start");
    for (int i = 0; i < 34; i++) cycle(0, 0, 1, 0, "clamp");
    cycle(1, 0, 1, 0, "zero_start");
    cycle(0, 0, 1, 0, "zero_after");

    // Restart at count=7, abort at count=3, abort with start.
    cycle(1, 0, 1, 12, "rs_start");
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, "rs_run");
    cycle(1, 0, 1, 10, "restart");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "rs_run2");
    cycle(0, 1, 1, 0, "abort");
    cycle(0, 0, 1, 0, "abort_idle");
    cycle(1, 0, 1, 5, "ab_start");
    cycle(1, 1, 1, 5, "abort_start");
    cycle(0, 0, 1, 0, "abort_start_idle");

    // Start coincident with final advance; then back-to-back runs via DONE.
    cycle(1, 0, 1, 3, "coll_start");
    cycle(0, 0, 1, 0, "coll_run");
    cycle(0, 0, 1, 0, "coll_last");
    cycle(1, 0, 1, 5, "collision");
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, "coll_run2");
    cycle(1, 0, 1, 2, "b2b_in_done");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, "b2b");

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 70), int'($urandom_range(0, 40)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
